// File: rtl/cmsdk_apb_master_pkg.sv
// cmsdk_apb_master_pkg: shared state encoding, response constants and timeout sizing
package cmsdk_apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // Counter must hold 0..cycles; a disabled timeout still gets a 1-bit counter
    function automatic int tmo_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cmsdk_apb_master_timeout.sv
// cmsdk_apb_master_timeout: saturating PREADY-low cycle counter with abort flag
module cmsdk_apb_master_timeout
    import cmsdk_apb_master_pkg::*;
#(
    parameter int LIMIT = 256,
    parameter int W     = tmo_width(LIMIT)
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] MAX  = W'(LIMIT);
    localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [W-1:0] cnt;

    // Count stalled access cycles, cleared at the start of every transfer, never wrapping
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != MAX)
            cnt <= cnt + W'(1);

    // Fires on the stalled cycle that brings the count up to LIMIT
    assign expired = (LIMIT != 0) && en && (cnt >= LAST);

endmodule

// File: rtl/cmsdk_apb_cmd_master.sv
// cmsdk_apb_cmd_master: valid/ready command stream to APB3 initiator with PREADY timeout
module cmsdk_apb_cmd_master
    import cmsdk_apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    state_t state, state_next;
    logic   accept, finish, tmo_expired;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_ready && cmd_valid;
    assign finish    = (state == ACCESS) && (PREADY || tmo_expired);

    cmsdk_apb_master_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (accept),
        .en      (state == ACCESS && !PREADY),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn)
            state <= IDLE;
        else
            state <= state_next;

    // Next-state: one transfer outstanding, response must be consumed before the next command
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = cmd_valid ? SETUP : IDLE;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = finish ? RESP : ACCESS;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Registered bus and response outputs; address/data only move on command acceptance
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= RSP_OK;
            rsp_timeout <= 1'b0;
        end else begin
            PSEL      <= (state_next == SETUP) || (state_next == ACCESS);
            PENABLE   <= (state_next == ACCESS);
            rsp_valid <= (state_next == RESP);
            if (accept) begin
                PADDR  <= cmd_addr & ~ADDR_WIDTH'(3);
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
            end
            if (finish) begin
                rsp_rdata   <= (PWRITE || !PREADY) ? '0 : PRDATA;
                rsp_err     <= PREADY ? (PSLVERR ? RSP_ERR : RSP_OK) : RSP_ERR;
                rsp_timeout <= !PREADY;
            end
        end

endmodule

// File: tb/tb_cmsdk_apb_cmd_master.sv
// tb_cmsdk_apb_cmd_master: directed checks of the APB command master against a small slave model
module tb_cmsdk_apb_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int vecs = 0;
    int errs = 0;

    int   waits = 0;
    logic stuck = 1'b0;
    logic slverr = 1'b0;
    int   acc_n = 0;
    logic lock = 1'b1;

    logic [31:0] r_data;
    logic        r_err, r_tmo, r_stable;
    int          r_lat, r_pen;

    cmsdk_apb_cmd_master #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: wait states counted per access, watchdog-style lock register at 0xC00
    always @(posedge PCLK) begin
        acc_n <= (PSEL && PENABLE && !PREADY) ? acc_n + 1 : 0;
        if (PSEL && PENABLE && PREADY && PWRITE && PADDR == 12'hC00)
            lock <= (PWDATA != 32'h1ACCE551);
    end

    assign PREADY  = !stuck && (acc_n >= waits);
    assign PSLVERR = slverr;
    assign PRDATA  = (PADDR == 12'hFF0) ? 32'h0000000D :
                     (PADDR == 12'hC00) ? {31'd0, lock} :
                     (PADDR == 12'h104) ? 32'hA5A55A5A : 32'hDEADBEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d);
        @(negedge PCLK);
        cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_valid = 1'b1;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        r_lat = 1; r_pen = 0; r_stable = 1'b1;
        while (!rsp_valid && r_lat < 50) begin
            if (PENABLE) r_pen++;
            if (PSEL && (PADDR !== (a & 12'hFFC) || PWRITE !== w)) r_stable = 1'b0;
            @(posedge PCLK);
            #1 r_lat++;
        end
        r_data = rsp_rdata; r_err = rsp_err; r_tmo = rsp_timeout;
        check("resp_psel_low", {31'd0, PSEL}, 0);
        if (rsp_ready) begin
            @(posedge PCLK);
            #1 check("resp_consumed", {31'd0, rsp_valid}, 0);
        end
    endtask

    initial begin
        #1 PRESETn = 1'b0;
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("rst_psel", {31'd0, PSEL}, 0);
        check("rst_penable", {31'd0, PENABLE}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        xfer(12'hFF0, 1'b0, 32'h0);
        check("wdog_rdata", r_data, 32'h0000000D);
        check("wdog_err", {31'd0, r_err}, 0);
        check("wdog_lat", r_lat, 3);
        check("wdog_pen", r_pen, 1);

        xfer(12'hC00, 1'b1, 32'h1ACCE551);
        check("unlock_wr_rdata", r_data, 0);
        xfer(12'hC00, 1'b0, 32'h0);
        check("unlock_rd", r_data, 0);
        xfer(12'hC00, 1'b1, 32'h1);
        check("lock_wr_rdata", r_data, 0);
        xfer(12'hC00, 1'b0, 32'h0);
        check("lock_rd", r_data, 1);

        waits = 3;
        xfer(12'h107, 1'b0, 32'h0);
        check("wait_rdata", r_data, 32'hA5A55A5A);
        check("wait_pen", r_pen, 4);
        check("wait_stable", {31'd0, r_stable}, 1);
        check("wait_lat", r_lat, 6);
        check("wait_paddr", {20'd0, PADDR}, 32'h104);
        waits = 0;

        stuck = 1'b1;
        xfer(12'h200, 1'b0, 32'h0);
        check("tmo_err", {31'd0, r_err}, 1);
        check("tmo_flag", {31'd0, r_tmo}, 1);
        check("tmo_rdata", r_data, 0);
        check("tmo_pen", r_pen, 4);
        check("tmo_lat", r_lat, 6);
        stuck = 1'b0;
        xfer(12'hFF0, 1'b0, 32'h0);
        check("post_tmo_rdata", r_data, 32'h0000000D);
        check("post_tmo_flag", {31'd0, r_tmo}, 0);

        slverr = 1'b1; rsp_ready = 1'b0;
        xfer(12'h010, 1'b1, 32'h12345678);
        check("slverr_err", {31'd0, r_err}, 1);
        check("slverr_tmo", {31'd0, r_tmo}, 0);
        check("slverr_rdata", r_data, 0);
        slverr = 1'b0;
        repeat (5) begin
            @(posedge PCLK);
            #1;
            check("bp_valid", {31'd0, rsp_valid}, 1);
            check("bp_err", {30'd0, rsp_err, rsp_timeout}, 32'h2);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 0);
            check("bp_psel", {31'd0, PSEL}, 0);
        end
        @(negedge PCLK) rsp_ready = 1'b1;
        @(posedge PCLK);
        #1;
        check("bp_release_valid", {31'd0, rsp_valid}, 0);
        check("bp_release_ready", {31'd0, cmd_ready}, 1);

        waits = 10;
        @(negedge PCLK);
        cmd_addr = 12'hFF0; cmd_write = 1'b0; cmd_valid = 1'b1;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(posedge PCLK);
        #1 check("mid_penable", {31'd0, PENABLE}, 1);
        PRESETn = 1'b0;
        #1;
        check("mid_rst_psel", {31'd0, PSEL}, 0);
        check("mid_rst_penable", {31'd0, PENABLE}, 0);
        check("mid_rst_valid", {31'd0, rsp_valid}, 0);
        @(negedge PCLK) PRESETn = 1'b1;
        waits = 0;
        r_pen = 0;
        repeat (6) begin
            @(posedge PCLK);
            #1 if (rsp_valid || PSEL) r_pen++;
        end
        check("mid_no_spurious", r_pen, 0);
        check("mid_cmd_ready", {31'd0, cmd_ready}, 1);
        xfer(12'hFF0, 1'b0, 32'h0);
        check("post_rst_rdata", r_data, 32'h0000000D);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cmsdk_apb_cmd_master.md
Name: cmsdk_apb_cmd_master

Overview:
- APB initiator that converts a simple valid/ready command stream into APB3 transfers (setup phase, then access phase).
- Returns each transfer's read data and error status on a valid/ready response channel.
- Drives APB slaves on the peripheral bus, for example the watchdog, timers and UARTs, from a test sequencer or lightweight DMA.
- Guards against a hung slave with a PREADY timeout.

Parameters:
- ADDR_WIDTH, 12, APB address width in bits; minimum 3.
- TIMEOUT_CYCLES, 256, number of access-phase cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- cmd_write  in  1  1=write, 0=read
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_WIDTH  APB address, {cmd_addr[ADDR_WIDTH-1:2],2'b00}
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready; tie high for APB2 slaves
- PSLVERR  in  1  APB error; tie low if unused

Behaviour:
- Reset (PRESETn low, asynchronous): state IDLE; all outputs 0 except cmd_ready=1; timeout counter 0.
- Reset asserted mid-transfer: the in-flight transfer is discarded silently and no response is produced.
- FSM states IDLE, SETUP, ACCESS, RESP.
  - All APB and response outputs are registered.
  - cmd_ready = (state==IDLE), combinational from state.
- IDLE: on cmd_valid, capture addr/write/wdata into PADDR/PWRITE/PWDATA; next state SETUP.
  - PWDATA is captured for reads as well.
- SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=1: rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err = PSLVERR; rsp_timeout = 0. Drop PSEL/PENABLE; go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and the count of PREADY-low access cycles reaches TIMEOUT_CYCLES: abort with rsp_rdata=0, rsp_err=1, rsp_timeout=1. Drop PSEL/PENABLE; go to RESP.
  - PREADY=1 on the same cycle the count reaches its limit: PREADY wins and the transfer completes normally.
- RESP: rsp_valid=1; response fields are held stable until rsp_ready. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE.
- Latency and throughput:
  - Zero-wait slave with rsp_ready held high: command accept to rsp_valid is 3 cycles.
  - Back-to-back throughput is one transfer per 4 cycles.
  - Each PREADY-low cycle adds one cycle.
- PADDR, PWRITE and PWDATA change only on command acceptance. They are held stable through SETUP/ACCESS and afterwards retain their last values, so there is no toggling while idle.
- PENABLE is never 1 while PSEL is 0. PSEL is never asserted in IDLE or RESP.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP and saturates without wrapping.
- Response backpressure: while in RESP, cmd_ready=0, so no new command is accepted until the response is consumed. Only one transfer is outstanding at a time.

Decomposition:
- Shared package cmsdk_apb_master_pkg holds:
  - state enum (IDLE/SETUP/ACCESS/RESP, 2-bit encoding)
  - response field constants (RSP_OK, RSP_ERR)
  - the timeout-counter width function
- One natural sub-module, cmsdk_apb_master_timeout: a saturating counter with clear/enable inputs and an expired output. The FSM and datapath stay in the top level.

Test Plan:
- Read 0xFF0 against the watchdog, PREADY=1, PSLVERR=0 → SETUP then ACCESS, one cycle each; rsp_rdata=0x0000000D, rsp_err=0, rsp_valid 3 cycles after accept.
- Write 0xC00=0x1ACCE551, then read 0xC00 → first rsp_rdata=0, second rsp_rdata=0x00000000. Then write 0xC00=0x1, read 0xC00 → rsp_rdata=0x00000001.
- BFM slave holding PREADY low 3 cycles on a read returning 0xA5A5_5A5A → PENABLE high 4 cycles; PADDR/PWRITE stable throughout; rsp_rdata=0xA5A55A5A; latency 6 cycles.
- TIMEOUT_CYCLES=4, PREADY stuck low → PSEL drops after 4 access cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Next command proceeds normally.
- Slave returns PSLVERR=1 with PREADY=1 on a write → rsp_err=1, rsp_timeout=0. With rsp_ready held low 5 cycles: rsp_valid and fields stable, cmd_ready=0, PSEL=0.
- Assert PRESETn low during ACCESS → PSEL, PENABLE and rsp_valid are 0 immediately; cmd_ready=1 after release; no spurious response.
